// File: rtl/hazard_issue_ctrl.sv
// Issue-stage hazard controller: tracks EX/MEM shadow stages and decides
// bubble, IF/ID hold, PC write and flush for the instruction in ID.
module hazard_issue_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  ID_Op_i,
  input  logic [4:0]  ID_RS1_i,
  input  logic [4:0]  ID_RS2_i,
  input  logic [4:0]  ID_RD_i,
  input  logic        Branch_taken_i,
  input  logic        MemStall_i,
  output logic        NoOp_o,
  output logic        Stall_o,
  output logic        PCWrite_o,
  output logic        Flush_o,
  output logic [15:0] StallCnt_o
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ex_rw, r_ex_mr, r_mem_rw, r_mem_mr;
  logic [4:0]  r_ex_rd, r_mem_rd;
  logic [15:0] r_cnt;

  logic w_use1, w_use2, w_wr, w_mr, w_beq;
  logic w_lu, w_bh, w_active;

  // Opcode class decode of the ID instruction
  always_comb begin
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    w_wr   = 1'b0;
    w_mr   = 1'b0;
    w_beq  = 1'b0;
    case (ID_Op_i)
      OP_R:    begin w_use1 = 1'b1; w_use2 = 1'b1; w_wr = 1'b1; end
      OP_I:    begin w_use1 = 1'b1; w_wr = 1'b1; end
      OP_LW:   begin w_use1 = 1'b1; w_wr = 1'b1; w_mr = 1'b1; end
      OP_SW:   begin w_use1 = 1'b1; w_use2 = 1'b1; end
      OP_BEQ:  begin w_use1 = 1'b1; w_use2 = 1'b1; w_beq = 1'b1; end
      default: begin w_use1 = 1'b0; end
    endcase
  end

  // Load-use and branch-operand hazard detection; x0 never conflicts
  always_comb begin
    w_lu = r_ex_mr && (r_ex_rd != 5'd0) &&
           ((w_use1 && (r_ex_rd == ID_RS1_i)) || (w_use2 && (r_ex_rd == ID_RS2_i)));
    w_bh = w_beq && (
           (r_ex_rw && (r_ex_rd != 5'd0) &&
            ((r_ex_rd == ID_RS1_i) || (r_ex_rd == ID_RS2_i))) ||
           (r_mem_mr && (r_mem_rd != 5'd0) &&
            ((r_mem_rd == ID_RS1_i) || (r_mem_rd == ID_RS2_i))));
    w_active = (r_state != S_IDLE);
  end

  // Control outputs, priority: idle, memory stall, hazard, taken branch, normal
  always_comb begin
    NoOp_o    = 1'b0;
    Stall_o   = 1'b0;
    PCWrite_o = 1'b1;
    Flush_o   = 1'b0;
    if (!w_active) begin
      NoOp_o    = 1'b1;
      Stall_o   = 1'b1;
      PCWrite_o = 1'b0;
    end else if (MemStall_i) begin
      Stall_o   = 1'b1;
      PCWrite_o = 1'b0;
    end else if (w_lu || w_bh) begin
      NoOp_o    = 1'b1;
      Stall_o   = 1'b1;
      PCWrite_o = 1'b0;
    end else if (w_beq && Branch_taken_i) begin
      Flush_o   = 1'b1;
    end else begin
      Flush_o   = 1'b0;
    end
  end

  assign StallCnt_o = r_cnt;

  // FSM, shadow pipeline and saturating stall counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_ex_rw  <= 1'b0;
      r_ex_mr  <= 1'b0;
      r_ex_rd  <= 5'd0;
      r_mem_rw <= 1'b0;
      r_mem_mr <= 1'b0;
      r_mem_rd <= 5'd0;
      r_cnt    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE:    r_state <= start_i ? S_RUN : S_IDLE;
        S_RUN:     r_state <= MemStall_i ? S_MEMWAIT : S_RUN;
        S_MEMWAIT: r_state <= MemStall_i ? S_MEMWAIT : S_RUN;
        default:   r_state <= S_IDLE;
      endcase
      if (!w_active) begin
        r_ex_rw  <= 1'b0;
        r_ex_mr  <= 1'b0;
        r_ex_rd  <= 5'd0;
        r_mem_rw <= 1'b0;
        r_mem_mr <= 1'b0;
        r_mem_rd <= 5'd0;
      end else if (!MemStall_i) begin
        r_mem_rw <= r_ex_rw;
        r_mem_mr <= r_ex_mr;
        r_mem_rd <= r_ex_rd;
        r_ex_rw  <= NoOp_o ? 1'b0 : w_wr;
        r_ex_mr  <= NoOp_o ? 1'b0 : w_mr;
        r_ex_rd  <= NoOp_o ? 5'd0 : ID_RD_i;
      end
      if (w_active && Stall_o && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses from an instruction-history
// reference model; a negedge monitor pops and compares against the DUT.
module tb_hazard_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [6:0]  ID_Op_i = 7'd0;
  logic [4:0]  ID_RS1_i = 5'd0, ID_RS2_i = 5'd0, ID_RD_i = 5'd0;
  logic        Branch_taken_i = 1'b0, MemStall_i = 1'b0;
  logic        NoOp_o, Stall_o, PCWrite_o, Flush_o;
  logic [15:0] StallCnt_o;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011, BEQ = 7'b1100011, OTH = 7'b1101111;

  hazard_issue_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ID_Op_i(ID_Op_i),
    .ID_RS1_i(ID_RS1_i), .ID_RS2_i(ID_RS2_i), .ID_RD_i(ID_RD_i),
    .Branch_taken_i(Branch_taken_i), .MemStall_i(MemStall_i),
    .NoOp_o(NoOp_o), .Stall_o(Stall_o), .PCWrite_o(PCWrite_o), .Flush_o(Flush_o),
    .StallCnt_o(StallCnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        noop, stall, pcw, flush;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd;
  } ins_t;

  exp_t sb[$];
  ins_t hist[$];   // instructions issued past ID, newest at the back
  bit   running;
  int   stalls;
  int   n_cmp = 0, n_bad = 0;

  function automatic bit reads1(input logic [6:0] op);
    return op == R || op == I || op == LW || op == SW || op == BEQ;
  endfunction
  function automatic bit reads2(input logic [6:0] op);
    return op == R || op == SW || op == BEQ;
  endfunction
  function automatic bit writes(input logic [6:0] op);
    return op == R || op == I || op == LW;
  endfunction

  function automatic void model_reset();
    ins_t nop;
    nop = '0;
    hist = {nop, nop};
    running = 0;
    stalls = 0;
  endfunction

  // Drive one cycle of inputs, push the expected response, advance the model.
  task automatic cycle(input logic st, input logic [6:0] op, input logic [4:0] a, b, d,
                       input logic bt, ms, rs);
    exp_t e;
    ins_t ex, mem, nw;
    bit   lu, bh;
    @(posedge clk_i); #1;
    start_i = st; ID_Op_i = op; ID_RS1_i = a; ID_RS2_i = b; ID_RD_i = d;
    Branch_taken_i = bt; MemStall_i = ms; rst_i = rs;
    if (rs) model_reset();
    ex  = hist[hist.size()-1];
    mem = hist[hist.size()-2];
    lu = (ex.op == LW) && ex.rd != 5'd0 &&
         ((reads1(op) && ex.rd == a) || (reads2(op) && ex.rd == b));
    bh = (op == BEQ) &&
         ((writes(ex.op) && ex.rd != 5'd0 && (ex.rd == a || ex.rd == b)) ||
          (mem.op == LW && mem.rd != 5'd0 && (mem.rd == a || mem.rd == b)));
    if (!running)      e = '{1'b1, 1'b1, 1'b0, 1'b0, 16'(stalls)};
    else if (ms)       e = '{1'b0, 1'b1, 1'b0, 1'b0, 16'(stalls)};
    else if (lu || bh) e = '{1'b1, 1'b1, 1'b0, 1'b0, 16'(stalls)};
    else if (op == BEQ && bt) e = '{1'b0, 1'b0, 1'b1, 1'b1, 16'(stalls)};
    else               e = '{1'b0, 1'b0, 1'b1, 1'b0, 16'(stalls)};
    sb.push_back(e);
    if (!rs) begin
      if (!running) running = st;
      else begin
        if (e.stall && stalls < 65535) stalls++;
        if (!ms) begin
          nw.op = e.noop ? 7'd0 : op;
          nw.rd = e.noop ? 5'd0 : d;
          hist.push_back(nw);
          void'(hist.pop_front());
        end
      end
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response
  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({NoOp_o, Stall_o, PCWrite_o, Flush_o, StallCnt_o} !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got noop=%b stall=%b pcw=%b flush=%b cnt=%0d, want noop=%b stall=%b pcw=%b flush=%b cnt=%0d",
                 $time, NoOp_o, Stall_o, PCWrite_o, Flush_o, StallCnt_o,
                 e.noop, e.stall, e.pcw, e.flush, e.cnt);
      end
    end
  end

  task automatic run(input logic [6:0] op, input logic [4:0] a, b, d, input logic bt, ms);
    cycle(1'b0, op, a, b, d, bt, ms, 1'b0);
  endtask

  initial begin
    model_reset();
    cycle(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);  // reset state
    cycle(1'b0, R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);     // idle, no start
    cycle(1'b1, R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);     // start
    run(R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);                   // add issues
    // lw x5 ; add x6,x5,x1 -> single bubble
    run(LW, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    run(R, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
    run(R, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
    // lw x5 ; beq x5,x0 taken -> two stalls then flush
    run(LW, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    repeat (3) run(BEQ, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0);
    run(I, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
    // lw x0 ; add x1,x0,x0 -> no stall
    run(LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    run(R, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    // mem stall during load-use, then the bubble
    run(LW, 5'd2, 5'd0, 5'd9, 1'b0, 1'b0);
    repeat (3) run(SW, 5'd9, 5'd4, 5'd0, 1'b0, 1'b1);
    repeat (2) run(SW, 5'd9, 5'd4, 5'd0, 1'b0, 1'b0);
    // async reset while in MEMWAIT
    run(R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    cycle(1'b0, R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    // randomized traffic with a small register pool to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      logic [6:0] op;
      case ($urandom_range(0, 5))
        0: op = R;  1: op = I;  2: op = LW;
        3: op = SW; 4: op = BEQ; default: op = OTH;
      endcase
      cycle(1'($urandom_range(0, 3) == 0), op, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 6) == 0),
            1'($urandom_range(0, 99) == 0));
    end
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk_i);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending responses, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_issue_ctrl.md
HAZARD_ISSUE_CTRL -- requirements
Module: hazard_issue_ctrl

Interface
REQ-001 clk_i  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_i  input  1  asynchronous, active-high reset.
REQ-003 start_i  input  1  leaves IDLE when sampled high.
REQ-004 ID_Op_i  input  7  opcode of instruction in ID.
REQ-005 ID_RS1_i / ID_RS2_i / ID_RD_i  input  5 each  register fields of ID instruction.
REQ-006 Branch_taken_i  input  1  ID comparator result; valid only when ID_Op_i=1100011.
REQ-007 MemStall_i  input  1  data memory busy; pipeline must freeze.
REQ-008 NoOp_o  output  1  to Control NoOp_i; forces bubble into ID/EX.
REQ-009 Stall_o  output  1  hold IF/ID register.
REQ-010 PCWrite_o  output  1  PC update enable.
REQ-011 Flush_o  output  1  clear IF/ID (taken branch).
REQ-012 StallCnt_o  output  16  saturating count of stall cycles.

Function
REQ-013 Opcode classes: R 0110011 (reads rs1,rs2; writes rd), I 0010011 (rs1; rd), lw 0000011 (rs1; rd; memread), sw 0100011 (rs1,rs2), beq 1100011 (rs1,rs2); other opcodes read nothing, write nothing.
REQ-014 Internal shadow stages EX and MEM, each {regwrite, memread, rd[4:0]}; rd=0 never creates a hazard.
REQ-015 FSM states IDLE, RUN, MEMWAIT; IDLE->RUN on start_i=1; RUN->MEMWAIT when MemStall_i=1; MEMWAIT->RUN first cycle MemStall_i=0; start_i ignored outside IDLE.
REQ-016 Outputs combinational from state, shadows and ID inputs; no output register latency.
REQ-017 IDLE: NoOp_o=1, Stall_o=1, PCWrite_o=0, Flush_o=0; shadows held at zero.
REQ-018 MemStall_i=1 (in RUN or MEMWAIT): NoOp_o=0, Stall_o=1, PCWrite_o=0, Flush_o=0; shadows frozen; highest priority.
REQ-019 Load-use hazard: EX.memread=1 and EX.rd equals a source read by ID instruction.
REQ-020 Branch data hazard: ID is beq and (EX.regwrite with EX.rd matching rs1/rs2, or MEM.memread with MEM.rd matching rs1/rs2).
REQ-021 Either hazard, no MemStall_i: NoOp_o=1, Stall_o=1, PCWrite_o=0, Flush_o=0.
REQ-022 No hazard, ID beq, Branch_taken_i=1: Flush_o=1, NoOp_o=0, Stall_o=0, PCWrite_o=1, one cycle.
REQ-023 Otherwise in RUN: NoOp_o=0, Stall_o=0, PCWrite_o=1, Flush_o=0.
REQ-024 Shadow advance each RUN edge without MemStall_i: MEM<=EX; EX<=ID class info if NoOp_o=0, else zero bubble.
REQ-025 lw followed by dependent beq yields exactly two stall cycles (EX then MEM match).
REQ-026 StallCnt_o increments on each edge with Stall_o=1 outside IDLE; saturates at 16'hFFFF.

Reset
REQ-027 rst_i=1 immediately: state IDLE, shadows zero, StallCnt_o=0, outputs per REQ-017, regardless of clock.
REQ-028 Reset mid-MEMWAIT or mid-stall discards all pending hazard state; restart requires start_i.

Verification
REQ-029 Reset then start_i=1, ID add x3,x1,x2 -> next cycle NoOp_o=0, PCWrite_o=1, StallCnt_o=0.
REQ-030 lw x5 then add x6,x5,x1 -> one cycle NoOp_o=1, Stall_o=1, PCWrite_o=0; StallCnt_o=1; add then issues.
REQ-031 lw x5 then beq x5,x0 taken -> two stall cycles, then Flush_o=1 one cycle; StallCnt_o=2.
REQ-032 lw x0 then add x1,x0,x0 -> no stall.
REQ-033 MemStall_i high 3 cycles during load-use hazard -> NoOp_o=0, shadows frozen, StallCnt_o+3, then single load-use bubble.
REQ-034 rst_i asserted between clock edges in MEMWAIT -> outputs revert to IDLE values before next edge, StallCnt_o=0.
